// File: rtl/mul_cell_sched_pkg.sv
// Shared definitions for the multiplier-cell scheduler.
//   state_e       : scheduler FSM encoding
//   CELL_LAT_MIN/MAX : legal range of the multiplier cell latency
//   CNT_W         : width of the WAIT down-counter (holds CELL_LAT_MAX-1)
package mul_cell_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int CELL_LAT_MIN = 1;
  localparam int CELL_LAT_MAX = 4;
  localparam int CNT_W        = 2;

endpackage

// File: rtl/mul_cell_sched_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req_i[1:0] : request lines
//   adv_i      : grant taken this cycle; remember who won
//   gnt_o[1:0] : one-hot grant (all zero when no request)
// On a tie the requester that did not win last time is granted. The
// last-grant register resets to 1 so requester 0 wins the first tie.
module rr_arb2
  import mul_cell_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (adv_i && (gnt_o != 2'b00)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/mul_cell_sched.sv
// Schedules two requesters onto a single shared 16x16 partial-product
// multiplier cell and assembles the low 32 bits of a*b.
//   req0_*/req1_*  : valid/ready operand handshakes (ready is a one-cycle accept)
//   cell_src1/2    : operands to the cell, cell_en its capture strobe
//   cell_p1..p3    : lo*lo, a_lo*b_hi, a_hi*b_lo, valid CELL_LAT cycles after capture
//   rsp_*          : result handshake, rsp_id names the owning requester
//   busy           : FSM not in IDLE
//
// state | meaning
// IDLE  | waiting for a request; grants and latches one operand pair
// ISSUE | cell_en high for one cycle with latched operands
// WAIT  | CELL_LAT cycles for the cell; result registered in the last one
// RESP  | rsp_valid high, result held until rsp_ready
module mul_cell_sched
  import mul_cell_sched_pkg::*;
#(
  parameter int CELL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy
);

  if (CELL_LAT < CELL_LAT_MIN || CELL_LAT > CELL_LAT_MAX) begin : g_bad_lat
    $error("mul_cell_sched: CELL_LAT out of range");
  end

  state_e             state_q, state_d;
  logic [31:0]        a_q, b_q, rsp_data_q;
  logic               id_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         gnt;
  logic               accept;
  logic [31:0]        cross_sum, result;

  assign accept = (state_q == IDLE) && (req0_valid || req1_valid);

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i ({req1_valid, req0_valid}),
    .adv_i (accept),
    .gnt_o (gnt)
  );

  // Cross terms are weighted by 2^16; anything above bit 31 is dropped.
  assign cross_sum = cell_p2 + cell_p3;
  assign result    = cell_p1 + (cross_sum << 16);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (cnt_q == '0) state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= gnt[1] ? req1_a : req0_a;
        b_q  <= gnt[1] ? req1_b : req0_b;
        id_q <= gnt[1];
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_W'(CELL_LAT - 1);
      end else if (state_q == WAIT) begin
        if (cnt_q == '0) begin
          rsp_data_q <= result;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  // Ready is combinational from the grant; reset masks it so nothing is
  // accepted while the block is being cleared.
  assign req0_ready = (state_q == IDLE) && !reset && gnt[0];
  assign req1_ready = (state_q == IDLE) && !reset && gnt[1];
  assign cell_en    = (state_q == ISSUE);
  assign cell_src1  = a_q;
  assign cell_src2  = b_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mul_cell_sched.sv
module tb_mul_cell_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] cell_src1, cell_src2, cell_p1, cell_p2, cell_p3;
  logic        cell_en, rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;

  logic        t3_req0_valid, t3_req1_valid, t3_req0_ready, t3_req1_ready;
  logic [31:0] t3_req0_a, t3_req0_b, t3_req1_a, t3_req1_b;
  logic [31:0] t3_cell_src1, t3_cell_src2, t3_cell_p1, t3_cell_p2, t3_cell_p3;
  logic        t3_cell_en, t3_rsp_valid, t3_rsp_ready, t3_rsp_id, t3_busy;
  logic [31:0] t3_rsp_data;

  mul_cell_sched #(.CELL_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  mul_cell_sched #(.CELL_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(t3_req0_valid), .req1_valid(t3_req1_valid),
    .req0_ready(t3_req0_ready), .req1_ready(t3_req1_ready),
    .req0_a(t3_req0_a), .req0_b(t3_req0_b), .req1_a(t3_req1_a), .req1_b(t3_req1_b),
    .cell_src1(t3_cell_src1), .cell_src2(t3_cell_src2), .cell_en(t3_cell_en),
    .cell_p1(t3_cell_p1), .cell_p2(t3_cell_p2), .cell_p3(t3_cell_p3),
    .rsp_valid(t3_rsp_valid), .rsp_ready(t3_rsp_ready), .rsp_id(t3_rsp_id),
    .rsp_data(t3_rsp_data), .busy(t3_busy)
  );

  // Cell models: operands captured on cell_en travel down a pipe of
  // CELL_LAT stages; non-capture cycles inject junk so products are only
  // correct in exactly the cycle CELL_LAT after the capture edge.
  localparam logic [63:0] JUNK = 64'h1234_5678_9ABC_DEF0;

  function automatic logic [31:0] pp(input logic [63:0] ab, input int k);
    logic [31:0] al, ah, bl, bh;
    al = {16'h0, ab[47:32]};
    ah = {16'h0, ab[63:48]};
    bl = {16'h0, ab[15:0]};
    bh = {16'h0, ab[31:16]};
    case (k)
      0: return al * bl;
      1: return al * bh;
      default: return ah * bl;
    endcase
  endfunction

  logic [63:0] pipe1_q;
  logic [63:0] pipe3_q [3];
  always @(posedge clk) begin
    pipe1_q    <= cell_en ? {cell_src1, cell_src2} : JUNK;
    pipe3_q[0] <= t3_cell_en ? {t3_cell_src1, t3_cell_src2} : JUNK;
    pipe3_q[1] <= pipe3_q[0];
    pipe3_q[2] <= pipe3_q[1];
  end
  assign cell_p1    = pp(pipe1_q, 0);
  assign cell_p2    = pp(pipe1_q, 1);
  assign cell_p3    = pp(pipe1_q, 2);
  assign t3_cell_p1 = pp(pipe3_q[2], 0);
  assign t3_cell_p2 = pp(pipe3_q[2], 1);
  assign t3_cell_p3 = pp(pipe3_q[2], 2);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One full operation on the CELL_LAT=1 instance with rsp_ready held high.
  task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_d, input logic exp_id, input string tag);
    int n;
    logic rdy;
    if (sel == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end
    #1;
    n = 0;
    rdy = (sel == 0) ? req0_ready : req1_ready;
    while (!rdy && n < 20) begin
      step();
      n++;
      rdy = (sel == 0) ? req0_ready : req1_ready;
    end
    chkb({tag, "_accept"}, rdy, 1'b1);
    chkb({tag, "_other_ready"}, (sel == 0) ? req1_ready : req0_ready, 1'b0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hA5A5_A5A5; req0_b = 32'h5A5A_5A5A;
    req1_a = 32'hC3C3_C3C3; req1_b = 32'h3C3C_3C3C;
    #1;
    chkb({tag, "_cell_en"}, cell_en, 1'b1);
    chk({tag, "_src1"}, cell_src1, a);
    n = 1;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd3);
    chk({tag, "_data"}, rsp_data, exp_d);
    chkb({tag, "_id"}, rsp_id, exp_id);
    step();
    chkb({tag, "_valid_drop"}, rsp_valid, 1'b0);
  endtask

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic        exp_id;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, gid, prev_cyc, acc_cyc;
    logic seen;

    vecs[0] = '{0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0};
    vecs[1] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[2] = '{0, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 1'b0};
    vecs[3] = '{1, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b1};
    vecs[4] = '{0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0};
    vecs[5] = '{1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};

    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h11; req0_b = 32'h22; req1_a = 32'h33; req1_b = 32'h44;
    rsp_ready = 1'b0;
    t3_req0_valid = 1'b0; t3_req1_valid = 1'b0;
    t3_req0_a = '0; t3_req0_b = '0; t3_req1_a = '0; t3_req1_b = '0;
    t3_rsp_ready = 1'b1;

    // Reset state, with both requests pending to show ready is masked.
    step(); step();
    chkb("rst_ready0", req0_ready, 1'b0);
    chkb("rst_ready1", req1_ready, 1'b0);
    chkb("rst_cell_en", cell_en, 1'b0);
    chk("rst_src1", cell_src1, 32'h0);
    chk("rst_src2", cell_src2, 32'h0);
    chkb("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chkb("rst_rsp_id", rsp_id, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_busy3", t3_busy, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    step();

    // Round robin with both requesters permanently valid.
    rsp_ready = 1'b1;
    req0_a = 32'd2; req0_b = 32'd3;
    req1_a = 32'd4; req1_b = 32'd5;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    prev_cyc = 0;
    for (int idx = 0; idx < 4; idx++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        if (rsp_valid) chk("rr_data", rsp_data, rsp_id ? 32'd20 : 32'd6);
        step();
        n++;
      end
      gid = req1_ready ? 1 : 0;
      acc_cyc = cyc;
      chkb("rr_seen", req0_ready || req1_ready, 1'b1);
      chkb("rr_onehot", req0_ready && req1_ready, 1'b0);
      chk("rr_order", gid, idx % 2);
      if (idx > 0) chk("rr_spacing", acc_cyc - prev_cyc, 32'd4);
      prev_cyc = acc_cyc;
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chkb("rr_last_valid", rsp_valid, 1'b1);
    chk("rr_last_data", rsp_data, 32'd20);
    chkb("rr_last_id", rsp_id, 1'b1);
    step();

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_id,
            $sformatf("vec%0d", i));
    end

    // Consumer stalls for 10 cycles in RESP while both requesters wait.
    rsp_ready = 1'b0;
    req1_a = 32'd3; req1_b = 32'd5; req1_valid = 1'b1;
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin
      step();
      n++;
    end
    chkb("stall_accept", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chkb("stall_rsp", rsp_valid, 1'b1);
    req0_a = 32'd100; req0_b = 32'd100; req1_a = 32'd200; req1_b = 32'd200;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chkb("stall_valid", rsp_valid, 1'b1);
      chk("stall_data", rsp_data, 32'd15);
      chkb("stall_id", rsp_id, 1'b1);
      chkb("stall_ready0", req0_ready, 1'b0);
      chkb("stall_ready1", req1_ready, 1'b0);
      chkb("stall_cell_en", cell_en, 1'b0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chkb("stall_release_valid", rsp_valid, 1'b0);
    chkb("stall_release_busy", busy, 1'b0);

    // Reset lands in WAIT: the operation must vanish without a response.
    req0_a = 32'h100; req0_b = 32'h100; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin
      step();
      n++;
    end
    chkb("abort_accept", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    step();
    chkb("abort_in_wait", busy, 1'b1);
    reset = 1'b1;
    step();
    chkb("abort_busy", busy, 1'b0);
    chkb("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_src1", cell_src1, 32'h0);
    chk("abort_data", rsp_data, 32'h0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | rsp_valid;
    end
    chkb("abort_no_rsp", seen, 1'b0);
    do_op(0, 32'd7, 32'd9, 32'h0000_003F, 1'b0, "post_rst");

    // CELL_LAT=3 instance, same operands as the first vector.
    t3_req0_a = 32'h0001_0003; t3_req0_b = 32'h0002_0005; t3_req0_valid = 1'b1;
    #1;
    n = 0;
    while (!t3_req0_ready && n < 20) begin
      step();
      n++;
    end
    chkb("lat3_accept", t3_req0_ready, 1'b1);
    step();
    t3_req0_valid = 1'b0; t3_req0_a = 32'hDEAD_BEEF; t3_req0_b = 32'hFEED_F00D;
    #1;
    chkb("lat3_cell_en", t3_cell_en, 1'b1);
    n = 1;
    while (!t3_rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("lat3_latency", n, 32'd5);
    chk("lat3_data", t3_rsp_data, 32'h000B_000F);
    chkb("lat3_id", t3_rsp_id, 1'b0);
    step();
    chkb("lat3_valid_drop", t3_rsp_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
